// File: rtl/cache_tag_lookup.sv
// 16-set, 4-way tag lookup with a two-stage request/response pipeline.
// Fills and invalidates write the arrays directly; lookups never see same-edge writes.

module cache_tag_way_cmp #(
  parameter int TW = 26
) (
  input  logic          vld,
  input  logic [TW-1:0] way_tag,
  input  logic [TW-1:0] look_tag,
  output logic          match,
  output logic          empty
);
  assign match = vld && (&(~(way_tag ^ look_tag)));
  assign empty = !vld;
endmodule

module cache_tag_lookup #(
  parameter int TW = 26
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic [TW+5:0] req_addr,
  output logic          req_ready,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic          resp_hit,
  output logic [1:0]    resp_way,
  output logic [1:0]    resp_victim,
  output logic [3:0]    resp_index,
  output logic [TW-1:0] resp_tag,
  input  logic          fill_en,
  input  logic [3:0]    fill_index,
  input  logic [1:0]    fill_way,
  input  logic [TW-1:0] fill_tag,
  input  logic          inv_all
);
  localparam int SETS = 16;
  localparam int WAYS = 4;

  logic [SETS-1:0][WAYS-1:0][TW-1:0] tag_arr;
  logic [SETS-1:0][WAYS-1:0]         vld_arr;
  logic [SETS-1:0][1:0]              rr_ptr;

  logic          s1_valid;
  logic [TW+5:2] s1_addr;
  logic [3:0]    s1_idx;
  logic [TW-1:0] s1_tag;
  logic          adv;

  logic [WAYS-1:0] match;
  logic [WAYS-1:0] empty;
  logic            hit;
  logic [1:0]      way_sel;
  logic [1:0]      victim;

  // Byte offset never affects the lookup.
  logic unused_offset;
  assign unused_offset = ^req_addr[1:0];

  assign adv       = !resp_valid || resp_ready;
  assign req_ready = adv;
  assign s1_idx    = s1_addr[5:2];
  assign s1_tag    = s1_addr[TW+5:6];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_tag_way_cmp #(.TW(TW)) u_cmp (
      .vld     (vld_arr[s1_idx][w]),
      .way_tag (tag_arr[s1_idx][w]),
      .look_tag(s1_tag),
      .match   (match[w]),
      .empty   (empty[w])
    );
  end

  // Descending scan so the lowest-numbered way has the last word.
  always_comb begin
    hit     = |match;
    way_sel = 2'd0;
    victim  = rr_ptr[s1_idx];
    for (int w = WAYS-1; w >= 0; w--) begin
      if (match[w]) way_sel = 2'(w);
      if (empty[w]) victim  = 2'(w);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_addr     <= '0;
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_way    <= 2'd0;
      resp_victim <= 2'd0;
      resp_index  <= 4'd0;
      resp_tag    <= '0;
    end else if (adv) begin
      s1_valid    <= req_valid;
      s1_addr     <= req_addr[TW+5:2];
      resp_valid  <= s1_valid;
      resp_hit    <= hit;
      resp_way    <= way_sel;
      resp_victim <= victim;
      resp_index  <= s1_idx;
      resp_tag    <= s1_tag;
    end
  end

  // Array maintenance ignores pipeline stalls; inv_all drops a concurrent fill.
  always_ff @(posedge clk) begin
    if (!rst_n || inv_all) begin
      vld_arr <= '0;
      rr_ptr  <= '0;
    end else if (fill_en) begin
      vld_arr[fill_index][fill_way] <= 1'b1;
      rr_ptr[fill_index]            <= rr_ptr[fill_index] + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && fill_en && !inv_all)
      tag_arr[fill_index][fill_way] <= fill_tag;
  end
endmodule

// File: tb/tb_cache_tag_lookup.sv
// Directed vector table, hand-written stall/reset sequences, then random traffic vs a reference model.

module tb_cache_tag_lookup;
  localparam int TW = 26;

  logic          clk = 1'b0;
  logic          rst_n, req_valid, req_ready, resp_valid, resp_ready, resp_hit;
  logic [TW+5:0] req_addr;
  logic [1:0]    resp_way, resp_victim, fill_way;
  logic [3:0]    resp_index, fill_index;
  logic [TW-1:0] resp_tag, fill_tag;
  logic          fill_en, inv_all;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cache_tag_lookup #(.TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hit(resp_hit), .resp_way(resp_way), .resp_victim(resp_victim),
    .resp_index(resp_index), .resp_tag(resp_tag), .fill_en(fill_en),
    .fill_index(fill_index), .fill_way(fill_way), .fill_tag(fill_tag),
    .inv_all(inv_all)
  );

  typedef struct {
    logic        rst;
    logic        rq;
    logic [31:0] addr;
    logic        fe;
    logic [3:0]  fi;
    logic [1:0]  fw;
    logic [25:0] ft;
    logic        inv;
    logic        all;
    logic        e_rv;
    logic        e_hit;
    logic [1:0]  e_way;
    logic [1:0]  e_vic;
    logic [3:0]  e_idx;
    logic [25:0] e_tag;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic rst, logic rq, logic [31:0] addr, logic fe,
                             logic [3:0] fi, logic [1:0] fw, logic [25:0] ft, logic inv,
                             logic all, logic e_rv, logic e_hit, logic [1:0] e_way,
                             logic [1:0] e_vic, logic [3:0] e_idx, logic [25:0] e_tag);
    vec_t r;
    r.rst = rst; r.rq = rq; r.addr = addr; r.fe = fe; r.fi = fi; r.fw = fw; r.ft = ft;
    r.inv = inv; r.all = all; r.e_rv = e_rv; r.e_hit = e_hit; r.e_way = e_way;
    r.e_vic = e_vic; r.e_idx = e_idx; r.e_tag = e_tag;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rst_n = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
    fill_en = 1'b0; fill_index = '0; fill_way = '0; fill_tag = '0; inv_all = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain arrays plus a two-slot pipeline.
  logic [25:0] m_tag[16][4];
  bit          m_vld[16][4];
  int          m_ptr[16];
  bit          m_s1v, m_rv, m_hit;
  logic [31:0] m_s1a;
  int          m_way, m_vic, m_idx;
  logic [25:0] m_tg;

  task automatic m_lookup(input logic [31:0] a, output bit h, output int w, output int vc,
                          output int ix, output logic [25:0] tg);
    ix = int'((a >> 2) & 32'hF);
    tg = 26'(a >> 6);
    h = 0; w = 0; vc = m_ptr[ix];
    for (int k = 3; k >= 0; k--) begin
      if (m_vld[ix][k] && m_tag[ix][k] == tg) begin h = 1; w = k; end
      if (!m_vld[ix][k]) vc = k;
    end
  endtask

  task automatic m_clear_arrays();
    for (int s = 0; s < 16; s++) begin
      m_ptr[s] = 0;
      for (int k = 0; k < 4; k++) m_vld[s][k] = 0;
    end
  endtask

  task automatic m_edge();
    if (!rst_n) begin
      m_s1v = 0; m_rv = 0; m_hit = 0; m_way = 0; m_vic = 0; m_idx = 0; m_tg = 0; m_s1a = 0;
      m_clear_arrays();
    end else begin
      if (!m_rv || resp_ready) begin
        m_lookup(m_s1a, m_hit, m_way, m_vic, m_idx, m_tg);
        m_rv  = m_s1v;
        m_s1v = req_valid;
        m_s1a = 32'(req_addr);
      end
      if (inv_all) m_clear_arrays();
      else if (fill_en) begin
        m_tag[fill_index][fill_way] = fill_tag;
        m_vld[fill_index][fill_way] = 1;
        m_ptr[fill_index] = (m_ptr[fill_index] + 1) % 4;
      end
    end
  endtask

  localparam logic [31:0] A = 32'h0000_1234;  // idx 13, tag 0x48
  localparam logic [31:0] B = 32'h0000_00B4;  // idx 13, tag 2
  localparam logic [31:0] C = 32'h0000_01F4;  // idx 13, tag 7

  initial begin
    idle();
    rst_n = 1'b0;

    //             rst rq addr fe fi  fw ft    inv all rv hit way vic idx tag
    tbl.push_back(v(0, 0, 0,   0, 0,  0, 0,    0,  1,  0, 0,  0,  0,  0,  0));
    tbl.push_back(v(0, 1, A,   0, 0,  0, 0,    0,  1,  0, 0,  0,  0,  0,  0));
    tbl.push_back(v(1, 1, A,   0, 0,  0, 0,    0,  0,  0, 0,  0,  0,  0,  0));
    tbl.push_back(v(1, 0, 0,   0, 0,  0, 0,    0,  0,  1, 0,  0,  0,  13, 26'h48));
    tbl.push_back(v(1, 0, 0,   1, 13, 2, 'h48, 0,  0,  0, 0,  0,  0,  0,  0));
    tbl.push_back(v(1, 1, A,   0, 0,  0, 0,    0,  0,  0, 0,  0,  0,  0,  0));
    tbl.push_back(v(1, 0, 0,   0, 0,  0, 0,    0,  0,  1, 1,  2,  0,  13, 26'h48));
    tbl.push_back(v(1, 0, 0,   1, 13, 0, 'h48, 1,  0,  0, 0,  0,  0,  0,  0));
    tbl.push_back(v(1, 1, A,   0, 0,  0, 0,    0,  0,  0, 0,  0,  0,  0,  0));
    tbl.push_back(v(1, 0, 0,   0, 0,  0, 0,    0,  0,  1, 0,  0,  0,  13, 26'h48));
    tbl.push_back(v(1, 0, 0,   1, 13, 0, 1,    0,  0,  0, 0,  0,  0,  0,  0));
    tbl.push_back(v(1, 0, 0,   1, 13, 1, 2,    0,  0,  0, 0,  0,  0,  0,  0));
    tbl.push_back(v(1, 0, 0,   1, 13, 2, 3,    0,  0,  0, 0,  0,  0,  0,  0));
    tbl.push_back(v(1, 0, 0,   1, 13, 3, 4,    0,  0,  0, 0,  0,  0,  0,  0));
    tbl.push_back(v(1, 1, A,   0, 0,  0, 0,    0,  0,  0, 0,  0,  0,  0,  0));
    tbl.push_back(v(1, 0, 0,   0, 0,  0, 0,    0,  0,  1, 0,  0,  0,  13, 26'h48));
    tbl.push_back(v(1, 0, 0,   1, 13, 0, 5,    0,  0,  0, 0,  0,  0,  0,  0));
    tbl.push_back(v(1, 1, A,   0, 0,  0, 0,    0,  0,  0, 0,  0,  0,  0,  0));
    tbl.push_back(v(1, 0, 0,   0, 0,  0, 0,    0,  0,  1, 0,  0,  1,  13, 26'h48));
    tbl.push_back(v(1, 1, B,   0, 0,  0, 0,    0,  0,  0, 0,  0,  0,  0,  0));
    tbl.push_back(v(1, 0, 0,   0, 0,  0, 0,    0,  0,  1, 1,  1,  1,  13, 2));
    tbl.push_back(v(1, 0, 0,   1, 13, 3, 2,    0,  0,  0, 0,  0,  0,  0,  0));
    tbl.push_back(v(1, 1, B,   0, 0,  0, 0,    0,  0,  0, 0,  0,  0,  0,  0));
    tbl.push_back(v(1, 0, 0,   0, 0,  0, 0,    0,  0,  1, 1,  1,  2,  13, 2));
    tbl.push_back(v(1, 1, C,   0, 0,  0, 0,    0,  0,  0, 0,  0,  0,  0,  0));
    tbl.push_back(v(1, 0, 0,   1, 13, 2, 7,    0,  0,  1, 0,  0,  2,  13, 7));
    tbl.push_back(v(1, 1, C,   0, 0,  0, 0,    0,  0,  0, 0,  0,  0,  0,  0));
    tbl.push_back(v(1, 0, 0,   0, 0,  0, 0,    0,  0,  1, 1,  2,  3,  13, 7));

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst; req_valid = tbl[i].rq; req_addr = tbl[i].addr; resp_ready = 1'b1;
      fill_en = tbl[i].fe; fill_index = tbl[i].fi; fill_way = tbl[i].fw;
      fill_tag = tbl[i].ft; inv_all = tbl[i].inv;
      step();
      chk($sformatf("v%0d resp_valid", i), 32'(resp_valid), 32'(tbl[i].e_rv));
      chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'd1);
      if (tbl[i].all || tbl[i].e_rv) begin
        chk($sformatf("v%0d hit", i), 32'(resp_hit), 32'(tbl[i].e_hit));
        chk($sformatf("v%0d way", i), 32'(resp_way), 32'(tbl[i].e_way));
        chk($sformatf("v%0d victim", i), 32'(resp_victim), 32'(tbl[i].e_vic));
        chk($sformatf("v%0d index", i), 32'(resp_index), 32'(tbl[i].e_idx));
        chk($sformatf("v%0d tag", i), 32'(resp_tag), 32'(tbl[i].e_tag));
      end
    end

    // Backpressure: A sits in stage 2, B waits in s1, C must not be taken.
    idle(); rst_n = 1'b0; step();
    rst_n = 1'b1; req_valid = 1'b1; req_addr = A; step();
    chk("bp first rv", 32'(resp_valid), 32'd0);
    req_addr = B; resp_ready = 1'b0; step();
    chk("bp rv", 32'(resp_valid), 32'd1);
    chk("bp ready low", 32'(req_ready), 32'd0);
    req_addr = C;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp hold rv", 32'(resp_valid), 32'd1);
      chk("bp hold ready", 32'(req_ready), 32'd0);
      chk("bp hold hit", 32'(resp_hit), 32'd0);
      chk("bp hold victim", 32'(resp_victim), 32'd0);
      chk("bp hold index", 32'(resp_index), 32'd13);
      chk("bp hold tag", 32'(resp_tag), 32'h48);
    end
    resp_ready = 1'b1; req_valid = 1'b0; step();
    chk("bp release rv", 32'(resp_valid), 32'd1);
    chk("bp release tag", 32'(resp_tag), 32'd2);
    step();
    chk("bp drained rv", 32'(resp_valid), 32'd0);
    step();
    chk("bp no C rv", 32'(resp_valid), 32'd0);

    // Mid-operation reset with a request in s1.
    req_valid = 1'b1; req_addr = A; step();
    req_valid = 1'b0; rst_n = 1'b0; step();
    chk("mrst rv", 32'(resp_valid), 32'd0);
    chk("mrst ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mrst stale rv", 32'(resp_valid), 32'd0);
    end

    // Random traffic over a small tag/set space so hits and full sets are common.
    idle(); rst_n = 1'b0;
    m_edge(); step();
    for (int c = 0; c < 3000; c++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      req_valid  = 1'($urandom_range(0, 1));
      req_addr   = (TW+6)'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2)
                           | $urandom_range(0, 3));
      resp_ready = ($urandom_range(0, 9) < 7);
      fill_en    = ($urandom_range(0, 3) == 0);
      fill_index = 4'($urandom_range(0, 3));
      fill_way   = 2'($urandom_range(0, 3));
      fill_tag   = TW'($urandom_range(0, 3));
      inv_all    = ($urandom_range(0, 59) == 0);
      m_edge();
      step();
      chk($sformatf("r%0d resp_valid", c), 32'(resp_valid), 32'(m_rv));
      chk($sformatf("r%0d req_ready", c), 32'(req_ready), 32'(!m_rv || resp_ready));
      if (m_rv) begin
        chk($sformatf("r%0d hit", c), 32'(resp_hit), 32'(m_hit));
        chk($sformatf("r%0d way", c), 32'(resp_way), 32'(m_way));
        chk($sformatf("r%0d victim", c), 32'(resp_victim), 32'(m_vic));
        chk($sformatf("r%0d index", c), 32'(resp_index), 32'(m_idx));
        chk($sformatf("r%0d tag", c), 32'(resp_tag), 32'(m_tg));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/cache_tag_lookup.md
CACHE_TAG_LOOKUP -- requirements
Module: cache_tag_lookup

Interface
REQ-001 Parameter TW, default 26, tag width in bits; request address width is TW+6.
REQ-002 Fixed geometry: 16 sets, 4 ways; addr[1:0] = byte offset (ignored), addr[5:2] = set index, addr[TW+5:6] = tag.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 req_valid  input  1  lookup request present.
REQ-007 req_addr  input  TW+6  lookup address.
REQ-008 req_ready  output  1  request accepted on an edge where req_valid && req_ready.
REQ-009 resp_valid  output  1  lookup result present.
REQ-010 resp_ready  input  1  consumer accepts the result.
REQ-011 resp_hit  output  1  tag matched a valid way.
REQ-012 resp_way  output  2  matching way; 0 on miss.
REQ-013 resp_victim  output  2  replacement way for this set; meaningful on miss.
REQ-014 resp_index  output  4  set index of the result.
REQ-015 resp_tag  output  TW  tag of the result.
REQ-016 fill_en  input  1  write a tag-array entry this edge.
REQ-017 fill_index  input  4  set to write.
REQ-018 fill_way  input  2  way to write.
REQ-019 fill_tag  input  TW  tag to write.
REQ-020 inv_all  input  1  clear all valid bits.

Function
REQ-021 State: tag array 16x4xTW, valid array 16x4, one 2-bit round-robin pointer per set, stage-1 register (s1_valid, addr), stage-2 register (the resp_* outputs).
REQ-022 Advance condition: adv = !resp_valid || resp_ready; req_ready SHALL equal adv combinationally.
REQ-023 On an edge with adv=1: s1 captures req_valid/req_addr, and stage 2 captures s1_valid plus the compare result for the s1 address; with adv=0 both stages hold.
REQ-024 Latency: a request accepted at edge N SHALL produce resp_valid=1 after edge N+1, given no stall.
REQ-025 Way match: valid[set][w] && (tag[set][w] == s1 tag), i.e. an AND-reduction of the bitwise XNOR word; with multiple matches, the lowest-numbered way wins.
REQ-026 Victim: the lowest-numbered invalid way of the set if any exists, else that set's round-robin pointer.
REQ-027 Fill: at the edge, tag[fill_index][fill_way] <= fill_tag, valid <= 1, and that set's pointer increments, wrapping 3->0.
REQ-028 The compare SHALL use array contents before the current edge; there is no bypass. A fill and a lookup in the same cycle are legal.
REQ-029 inv_all: at the edge, all valid bits <= 0 and all pointers <= 0. If fill_en is asserted in the same cycle, inv_all wins and the fill is dropped.
REQ-030 Fill and inv_all SHALL act regardless of adv.
REQ-031 A response held under stall SHALL keep every resp_* output stable until accepted.

Reset
REQ-032 With rst_n=0 at an edge: s1_valid, resp_valid, resp_hit, resp_way, resp_victim, resp_index and resp_tag <= 0; all valid bits <= 0; all pointers <= 0; tag contents are unspecified.
REQ-033 Reset SHALL override any in-flight request, fill, or stall; no response for a pre-reset request SHALL appear afterwards.
REQ-034 With rst_n=0, req_ready SHALL be 1, because resp_valid=0.

Verification
REQ-035 Cold miss: after reset, request 0x00001234 (index 13, tag 0x48) -> 2 edges later resp_valid=1, hit=0, way=0, victim=0, index=13, tag=0x48.
REQ-036 Hit: fill index 13, way 2, tag 0x48; then request 0x00001234 -> hit=1, way=2.
REQ-037 Round-robin: fill ways 0,1,2,3 of set 13 with tags 1..4, then request a tag-0x48 miss -> victim=0 (pointer wrapped after 4 fills); one more fill to set 13 -> next miss victim=1.
REQ-038 Backpressure: hold resp_ready=0 with the response valid for 3 cycles -> req_ready=0 and resp_* stable; raise resp_ready -> the queued s1 request appears on the next edge.
REQ-039 Invalidate: after the REQ-036 fill, pulse inv_all together with fill_en -> the next request 0x00001234 misses with victim=0.
REQ-040 Mid-operation reset: drop rst_n for one edge with a request in s1 -> resp_valid stays 0 after reset and no stale response appears.
